ysyx_040066_cache_arbiter: RTL and testbench

// Shares one line-granular memory master (addr/rd_req/rd_last/wr_req/512b wr_data) between the
// I-cache (port c0) and D-cache (port c1) miss/writeback/fence engines. Grants one owner per

---
 rtl/ysyx_040066_cache_arbiter_pkg.sv | 15 +
 rtl/ysyx_040066_cache_arbiter_if.sv | 30 +++
 rtl/ysyx_040066_cache_arbiter_rr_arb2.sv | 18 +
 rtl/ysyx_040066_cache_arbiter.sv | 113 +++++++++++
 tb/tb_ysyx_040066_cache_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_040066_cache_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: state encoding and default bus widths.
package ysyx_040066_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int LINE_LEN = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD      = 2'b01,
    WR      = 2'b10,
    POST_WR = 2'b11
  } arbState_e;

endpackage

// File: rtl/ysyx_040066_cache_arbiter_if.sv
// Line-granular memory bus: the requester (master) drives address/requests/line,
// the responder (slave) returns read beats and write acknowledgements.
interface ysyx_040066_cache_arbiter_if #(
  parameter int ADDR_W   = ysyx_040066_pkg::ADDR_W,
  parameter int DATA_W   = ysyx_040066_pkg::DATA_W,
  parameter int LINE_LEN = ysyx_040066_pkg::LINE_LEN
);

  logic [ADDR_W-1:0]   addr;
  logic                rd_req;
  logic                wr_req;
  logic [LINE_LEN-1:0] wr_data;
  logic                rd_ready;
  logic                rd_last;
  logic                rd_error;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_ready;
  logic                wr_error;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_ready, rd_last, rd_error, rd_data, wr_ready, wr_error
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_ready, rd_last, rd_error, rd_data, wr_ready, wr_error
  );

endinterface

// File: rtl/ysyx_040066_cache_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module ysyx_040066_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    case (req_i)
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_040066_cache_arbiter.sv
// Shares one memory master between the I-cache (c0) and D-cache (c1), one owner per burst,
// keeping a writeback and the refill that follows it under a single grant.
module ysyx_040066_cache_arbiter #(
  parameter int ADDR_W   = ysyx_040066_pkg::ADDR_W,
  parameter int DATA_W   = ysyx_040066_pkg::DATA_W,
  parameter int LINE_LEN = ysyx_040066_pkg::LINE_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_040066_cache_arbiter_if.slave    c0_if,
  ysyx_040066_cache_arbiter_if.slave    c1_if,
  ysyx_040066_cache_arbiter_if.master   m_if,
  output logic                          busy_o
);

  import ysyx_040066_pkg::*;

  arbState_e           state_q, state_d;
  logic                owner_q, owner_d;
  logic                lastGrant_q, lastGrant_d;
  logic [1:0]          req;
  logic                gnt;
  logic                anyReq;
  logic                ownRd;
  logic                ownWr;
  logic                winWr;
  logic [ADDR_W-1:0]   ownAddr;
  logic [LINE_LEN-1:0] ownWrData;
  logic [DATA_W-1:0]   rdBeat;
  logic                busy;
  logic                fwd;

  assign req = {c1_if.rd_req | c1_if.wr_req, c0_if.rd_req | c0_if.wr_req};

  ysyx_040066_rr_arb2 u_rrArb (
    .req_i  (req),
    .last_i (lastGrant_q),
    .gnt_o  (gnt),
    .any_o  (anyReq)
  );

  always_comb begin
    ownRd     = owner_q ? c1_if.rd_req  : c0_if.rd_req;
    ownWr     = owner_q ? c1_if.wr_req  : c0_if.wr_req;
    ownAddr   = owner_q ? c1_if.addr    : c0_if.addr;
    ownWrData = owner_q ? c1_if.wr_data : c0_if.wr_data;
    winWr     = gnt ? c1_if.wr_req : c0_if.wr_req;
  end

  // A dropped request without its handshake abandons the burst; POST_WR lets the
  // writeback owner roll straight into its refill without re-arbitrating.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d     = gnt;
          lastGrant_d = gnt;
          state_d     = winWr ? WR : RD;
        end
      end
      RD: begin
        if (!ownRd || (m_if.rd_ready && m_if.rd_last)) state_d = IDLE;
      end
      WR: begin
        if (ownWr && m_if.wr_ready) state_d = POST_WR;
        else if (!ownWr)            state_d = IDLE;
      end
      POST_WR: state_d = ownRd ? RD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign fwd    = (state_q == RD) || (state_q == WR);
  assign busy_o = busy;
  assign rdBeat = busy ? m_if.rd_data : '0;

  assign m_if.addr    = busy ? ownAddr : '0;
  assign m_if.wr_data = busy ? ownWrData : '0;
  assign m_if.rd_req  = (state_q == RD) && ownRd;
  assign m_if.wr_req  = (state_q == WR) && ownWr;

  // Bridge responses reach only the current owner, and only during an active burst.
  assign c0_if.rd_ready = fwd && !owner_q && m_if.rd_ready;
  assign c0_if.rd_last  = fwd && !owner_q && m_if.rd_last;
  assign c0_if.rd_error = fwd && !owner_q && m_if.rd_error;
  assign c0_if.wr_ready = fwd && !owner_q && m_if.wr_ready;
  assign c0_if.wr_error = fwd && !owner_q && m_if.wr_error;
  assign c0_if.rd_data  = rdBeat;

  assign c1_if.rd_ready = fwd && owner_q && m_if.rd_ready;
  assign c1_if.rd_last  = fwd && owner_q && m_if.rd_last;
  assign c1_if.rd_error = fwd && owner_q && m_if.rd_error;
  assign c1_if.wr_ready = fwd && owner_q && m_if.wr_ready;
  assign c1_if.wr_error = fwd && owner_q && m_if.wr_error;
  assign c1_if.rd_data  = rdBeat;

endmodule

// File: tb/tb_ysyx_040066_cache_arbiter.sv
// Self-checking bench for the cache arbiter: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model of grants and bursts.
module tb_ysyx_040066_cache_arbiter;

  logic clk;
  logic rst;
  logic busy;

  logic        cRd[2];
  logic        cWr[2];
  logic [31:0] cAddr[2];
  logic [511:0] cWd[2];
  logic        mRdReady, mRdLast, mRdError, mWrReady, mWrError;
  logic [63:0] mRdData;

  logic        gotRdReady[2], gotRdLast[2], gotRdError[2], gotWrReady[2], gotWrError[2];
  logic [63:0] gotRdData[2];

  int checks = 0;
  int errors = 0;
  bit checkEnable = 0;

  string phase = "idle";
  int    holder = 0;
  int    lastWinner = 0;

  int c1Beats, c1Lasts, c0Beats;

  ysyx_040066_cache_arbiter_if c0If ();
  ysyx_040066_cache_arbiter_if c1If ();
  ysyx_040066_cache_arbiter_if mIf ();

  ysyx_040066_cache_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .c0_if  (c0If),
    .c1_if  (c1If),
    .m_if   (mIf),
    .busy_o (busy)
  );

  assign c0If.rd_req  = cRd[0];
  assign c0If.wr_req  = cWr[0];
  assign c0If.addr    = cAddr[0];
  assign c0If.wr_data = cWd[0];
  assign c1If.rd_req  = cRd[1];
  assign c1If.wr_req  = cWr[1];
  assign c1If.addr    = cAddr[1];
  assign c1If.wr_data = cWd[1];

  assign mIf.rd_ready = mRdReady;
  assign mIf.rd_last  = mRdLast;
  assign mIf.rd_error = mRdError;
  assign mIf.rd_data  = mRdData;
  assign mIf.wr_ready = mWrReady;
  assign mIf.wr_error = mWrError;

  assign gotRdReady[0] = c0If.rd_ready;
  assign gotRdLast[0]  = c0If.rd_last;
  assign gotRdError[0] = c0If.rd_error;
  assign gotWrReady[0] = c0If.wr_ready;
  assign gotWrError[0] = c0If.wr_error;
  assign gotRdData[0]  = c0If.rd_data;
  assign gotRdReady[1] = c1If.rd_ready;
  assign gotRdLast[1]  = c1If.rd_last;
  assign gotRdError[1] = c1If.rd_error;
  assign gotWrReady[1] = c1If.wr_ready;
  assign gotWrError[1] = c1If.wr_error;
  assign gotRdData[1]  = c1If.rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow from who holds the bus and what kind of burst it is running.
  task automatic checkOutput();
    bit busyE;
    bit fwd;
    bit own;
    busyE = (phase != "idle");
    fwd   = (phase == "read") || (phase == "write");
    checkVal("busy", busy, busyE);
    checkVal("m_addr", mIf.addr, busyE ? cAddr[holder] : 32'h0);
    checkVal("m_wr_data", mIf.wr_data, busyE ? cWd[holder] : 512'h0);
    checkVal("m_rd_req", mIf.rd_req, (phase == "read") && cRd[holder]);
    checkVal("m_wr_req", mIf.wr_req, (phase == "write") && cWr[holder]);
    for (int p = 0; p < 2; p++) begin
      own = fwd && (holder == p);
      checkVal($sformatf("c%0d_rd_ready", p), gotRdReady[p], own && mRdReady);
      checkVal($sformatf("c%0d_rd_last", p),  gotRdLast[p],  own && mRdLast);
      checkVal($sformatf("c%0d_rd_error", p), gotRdError[p], own && mRdError);
      checkVal($sformatf("c%0d_wr_ready", p), gotWrReady[p], own && mWrReady);
      checkVal($sformatf("c%0d_wr_error", p), gotWrError[p], own && mWrError);
      checkVal($sformatf("c%0d_rd_data", p),  gotRdData[p],  busyE ? mRdData : 64'h0);
    end
  endtask

  task automatic modelStep();
    bit r0;
    bit r1;
    if (rst) begin
      phase = "idle";
      holder = 0;
      lastWinner = 0;
      return;
    end
    r0 = cRd[0] || cWr[0];
    r1 = cRd[1] || cWr[1];
    if (phase == "idle") begin
      if (r0 || r1) begin
        holder = (r0 && r1) ? 1 - lastWinner : (r1 ? 1 : 0);
        lastWinner = holder;
        phase = cWr[holder] ? "write" : "read";
      end
    end else if (phase == "read") begin
      if (!cRd[holder] || (mRdReady && mRdLast)) phase = "idle";
    end else if (phase == "write") begin
      if (cWr[holder] && mWrReady) phase = "post";
      else if (!cWr[holder])       phase = "idle";
    end else begin
      phase = cRd[holder] ? "read" : "idle";
    end
  endtask

  always @(negedge clk) begin
    if (checkEnable) checkOutput();
    modelStep();
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    for (int p = 0; p < 2; p++) begin
      cRd[p] = 0;
      cWr[p] = 0;
    end
    mRdReady = 0; mRdLast = 0; mRdError = 0;
    mWrReady = 0; mWrError = 0;
  endtask

  task automatic applyReset();
    rst = 1;
    clearInputs();
    cycle();
    cycle();
    rst = 0;
  endtask

  // Requests persist for a while and occasionally drop; the bridge answers at random.
  task automatic applyStimulus();
    for (int p = 0; p < 2; p++) begin
      if ($urandom_range(0, 7) == 0) cRd[p] = ~cRd[p];
      if ($urandom_range(0, 9) == 0) cWr[p] = ~cWr[p];
      if (!cRd[p] && !cWr[p]) begin
        cAddr[p] = $urandom & 32'hFFFF_FFC0;
        for (int i = 0; i < 16; i++) cWd[p][i*32 +: 32] = $urandom;
      end
    end
    mRdReady = 1'($urandom_range(0, 1));
    mRdLast  = mRdReady && ($urandom_range(0, 3) == 0);
    mRdError = ($urandom_range(0, 15) == 0);
    mWrReady = ($urandom_range(0, 2) == 0);
    mWrError = ($urandom_range(0, 15) == 0);
    mRdData  = {$urandom, $urandom};
    rst      = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    rst = 1;
    clearInputs();
    for (int p = 0; p < 2; p++) begin
      cAddr[p] = 32'h0;
      cWd[p] = 512'h0;
    end
    mRdData = 64'h0;
    cycle();
    checkEnable = 1;
    cycle();
    rst = 0;
    @(negedge clk);
    checkVal("reset busy", busy, 0);
    checkVal("reset m_rd_req", mIf.rd_req, 0);
    cycle();

    // D-cache alone reads an 8-beat line.
    cRd[1] = 1;
    cAddr[1] = 32'h8000_1040;
    @(negedge clk);
    checkVal("t1 no req while arbitrating", mIf.rd_req, 0);
    cycle();
    c1Beats = 0; c1Lasts = 0; c0Beats = 0;
    for (int b = 1; b <= 8; b++) begin
      mRdReady = 1;
      mRdLast = (b == 8);
      mRdData = 64'h1111_0000_0000_0000 + 64'(b);
      @(negedge clk);
      if (b == 1) checkVal("t1 m_addr", mIf.addr, 32'h8000_1040);
      c1Beats += int'(c1If.rd_ready);
      c1Lasts += int'(c1If.rd_last);
      c0Beats += int'(c0If.rd_ready);
      cycle();
    end
    mRdReady = 0; mRdLast = 0; cRd[1] = 0;
    @(negedge clk);
    checkVal("t1 busy after last", busy, 0);
    checkVal("t1 c1 beats", 32'(c1Beats), 32'd8);
    checkVal("t1 c1 lasts", 32'(c1Lasts), 32'd1);
    checkVal("t1 c0 beats", 32'(c0Beats), 32'd0);

    // Tie after reset goes to the D-cache, then alternates.
    applyReset();
    cRd[0] = 1; cRd[1] = 1;
    cAddr[0] = 32'h0000_2000; cAddr[1] = 32'h8000_3000;
    cycle();
    mRdReady = 1;
    @(negedge clk);
    checkVal("t2 first tie", mIf.addr, 32'h8000_3000);
    checkVal("t2 c0 no beat", c0If.rd_ready, 0);
    cycle();
    mRdLast = 1;
    cycle();
    cRd[1] = 0; mRdReady = 0; mRdLast = 0;
    @(negedge clk);
    checkVal("t2 idle gap", busy, 0);
    cycle();
    mRdReady = 1; mRdLast = 1;
    @(negedge clk);
    checkVal("t2 c0 granted", mIf.addr, 32'h0000_2000);
    checkVal("t2 c0 last", c0If.rd_last, 1);
    cycle();
    mRdReady = 0; mRdLast = 0; cRd[1] = 1;
    cycle();
    mRdReady = 1; mRdLast = 1;
    @(negedge clk);
    checkVal("t2 second tie", mIf.addr, 32'h8000_3000);
    cycle();
    clearInputs();

    // Writeback then refill stays with the D-cache while the I-cache waits.
    applyReset();
    cWr[1] = 1; cAddr[1] = 32'h8000_4000;
    for (int i = 0; i < 16; i++) cWd[1][i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    cRd[0] = 1; cAddr[0] = 32'h0000_5000;
    @(negedge clk);
    checkVal("t3 no wr while arbitrating", mIf.wr_req, 0);
    cycle();
    @(negedge clk);
    checkVal("t3 wr granted", mIf.wr_req, 1);
    checkVal("t3 wr addr", mIf.addr, 32'h8000_4000);
    checkVal("t3 wr line word0", 512'(mIf.wr_data[31:0]), 512'h A5A5_0000);
    cycle();
    mWrReady = 1; cRd[1] = 1;
    @(negedge clk);
    checkVal("t3 c1 wr_ready", c1If.wr_ready, 1);
    checkVal("t3 c0 wr_ready", c0If.wr_ready, 0);
    cycle();
    mWrReady = 0; cWr[1] = 0;
    @(negedge clk);
    checkVal("t3 post busy", busy, 1);
    checkVal("t3 post no rd_req", mIf.rd_req, 0);
    cycle();
    mRdReady = 1; mRdLast = 1;
    @(negedge clk);
    checkVal("t3 refill addr", mIf.addr, 32'h8000_4000);
    checkVal("t3 refill rd_req", mIf.rd_req, 1);
    cycle();
    mRdReady = 0; mRdLast = 0; cRd[1] = 0;
    @(negedge clk);
    checkVal("t3 idle after refill", busy, 0);
    cycle();
    @(negedge clk);
    checkVal("t3 c0 after c1", mIf.addr, 32'h0000_5000);

    // I-cache abandons its read; the waiting D-cache is granted afterwards.
    cycle();
    cRd[0] = 0; cRd[1] = 1; cAddr[1] = 32'h8000_6000;
    @(negedge clk);
    checkVal("t4 rd_req follows drop", mIf.rd_req, 0);
    cycle();
    @(negedge clk);
    checkVal("t4 abandoned idle", busy, 0);
    cycle();
    mRdReady = 1; mRdError = 1;
    @(negedge clk);
    checkVal("t4 c1 granted", mIf.addr, 32'h8000_6000);
    checkVal("t5 c1 rd_error", c1If.rd_error, 1);
    checkVal("t5 c0 rd_error", c0If.rd_error, 0);
    cycle();
    mRdError = 0; mRdLast = 1;
    cycle();
    mRdReady = 0; mRdLast = 0; cRd[1] = 0; cWr[1] = 1;
    cycle();
    mWrReady = 1; mWrError = 1;
    @(negedge clk);
    checkVal("t5 c1 wr_error", c1If.wr_error, 1);
    checkVal("t5 c0 wr_error", c0If.wr_error, 0);
    cycle();
    clearInputs();
    cycle();

    // Reset on the fourth beat of an I-cache burst.
    cRd[0] = 1; cAddr[0] = 32'h0000_7000;
    cycle();
    for (int b = 1; b <= 4; b++) begin
      mRdReady = 1;
      if (b == 4) rst = 1;
      @(negedge clk);
      cycle();
    end
    rst = 0; cRd[0] = 0;
    @(negedge clk);
    checkVal("t6 busy after rst", busy, 0);
    checkVal("t6 m_rd_req after rst", mIf.rd_req, 0);
    checkVal("t6 m_wr_req after rst", mIf.wr_req, 0);
    checkVal("t6 c0 ignores beat", c0If.rd_ready, 0);
    cycle();
    clearInputs();

    for (int n = 0; n < 2000; n++) begin
      cycle();
      applyStimulus();
    end
    cycle();
    rst = 0;
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
